uart_tx_ctrl: RTL and testbench

// - RS232 UART transmitter: 8 data bits, no parity, 1 stop bit, LSB first.
// - Contains its own baud counter, bit counter, shift register and control FSM.
// - Sits beside the UART receiver in the UART peripheral. Driven by the

---
 rtl/uart_tx_ctrl.sv | 139 +++++++++++++
 tb/tb_uart_tx_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: 8N1 RS232 transmitter, LSB first, idle line high.
// A frame is a start bit (0), eight data bits from a shift register
// loaded when the request is accepted, and a stop bit (1). Each bit
// lasts BAUD_DIV clocks. A one-clock DONE state follows the stop bit
// and raises done_o.
//
// Handshake: tx_start_i is a level request. It is accepted on a rising
// clk edge when the FSM is in IDLE, or on the DONE exit edge so that a
// held request sends frames back-to-back with exactly one idle clock
// between them. At the accepting edge tx_data_i is copied into the shift
// register. While busy_o=1 the request is ignored and never queued.
//
// All outputs come from flops or straight from the state register.
// fsm_state mirrors the state register for observation.

module uart_tx_ctrl #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data_i,
  input  logic       tx_start_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [2:0] fsm_state
);

  // Baud counter width; a 1-bit counter still works for BAUD_DIV == 2.
  localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;

  logic          baud_last;
  logic [7:0]    shift_next;
  logic          accept;

  // Terminal count of the current bit slot.
  assign baud_last  = (baud_cnt == BAUD_LAST);
  // Shift register contents after the current data bit has been sent.
  assign shift_next = {1'b0, shift_reg[7:1]};
  // A request is taken in IDLE or on the single DONE clock.
  assign accept     = tx_start_i && ((state == S_IDLE) || (state == S_DONE));
  // Expose the state register for observation.
  assign fsm_state  = state;

  // Control FSM with counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      tx_o      <= 1'b1;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (accept) begin
        // Latch the byte and drive the start bit from this edge on.
        shift_reg <= tx_data_i;
        baud_cnt  <= '0;
        bit_cnt   <= '0;
        state     <= S_START;
        tx_o      <= 1'b0;
        busy_o    <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            tx_o   <= 1'b1;
            busy_o <= 1'b0;
          end
          S_START: begin
            if (baud_last) begin
              baud_cnt <= '0;
              state    <= S_DATA;
              tx_o     <= shift_reg[0];
            end else begin
              baud_cnt <= baud_cnt + BW'(1);
            end
          end
          S_DATA: begin
            if (baud_last) begin
              baud_cnt  <= '0;
              shift_reg <= shift_next;
              // bit_cnt wraps 7 -> 0 as the last data bit ends.
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= S_STOP;
                tx_o  <= 1'b1;
              end else begin
                tx_o  <= shift_next[0];
              end
            end else begin
              baud_cnt <= baud_cnt + BW'(1);
            end
          end
          S_STOP: begin
            tx_o <= 1'b1;
            if (baud_last) begin
              baud_cnt <= '0;
              state    <= S_DONE;
              done_o   <= 1'b1;
            end else begin
              baud_cnt <= baud_cnt + BW'(1);
            end
          end
          S_DONE: begin
            // No pending request: return to IDLE and drop busy.
            state  <= S_IDLE;
            tx_o   <= 1'b1;
            busy_o <= 1'b0;
          end
          default: begin
            // Unreachable encodings fall back to a clean idle line.
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_o     <= 1'b1;
            busy_o   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: checks the UART transmitter with BAUD_DIV=4 (slot-exact
// line checks, scoreboard decode of every frame) and BAUD_DIV=434.

module tb_uart_tx_ctrl;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUTs ----------------
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_o, busy_o, done_o;
  logic [2:0] fsm_state;

  uart_tx_ctrl #(.BAUD_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data_i  (tx_data),
    .tx_start_i (tx_start),
    .tx_o       (tx_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .fsm_state  (fsm_state)
  );

  logic [7:0] big_data;
  logic       big_start;
  logic       big_tx, big_busy, big_done;
  logic [2:0] big_state;

  uart_tx_ctrl #(.BAUD_DIV(434)) dut_big (
    .clk        (clk),
    .rst        (rst),
    .tx_data_i  (big_data),
    .tx_start_i (big_start),
    .tx_o       (big_tx),
    .busy_o     (big_busy),
    .done_o     (big_done),
    .fsm_state  (big_state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int rst_count = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Count done pulses as seen at the sampling edge.
  always @(negedge clk) if (done_o === 1'b1) done_seen++;

  // Count reset assertions so the monitor can drop aborted frames.
  always @(posedge rst) rst_count++;

  // Watchdog: the whole run is a fixed schedule well below this bound.
  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitor (BAUD_DIV=4 line) ----------------
  initial begin : monitor
    logic [7:0] got;
    logic       stop_bit;
    int         rc0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx_o === 1'b0) begin
        rc0 = rst_count;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          got[i] = tx_o;
        end
        repeat (4) @(negedge clk);
        stop_bit = tx_o;
        if (rst_count == rc0) begin
          chk("sb_stop_bit", stop_bit, 1'b1);
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_frame", got, 8'hxx);
          end else begin
            chk("sb_byte", got, exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Drive a request so the next rising edge (edge N) accepts it; return at
  // the falling edge after edge N. hold keeps the request asserted.
  task automatic issue(input logic [7:0] d, input bit push, input bit hold);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    if (push) exp_q.push_back(d);
    @(posedge clk);
    @(negedge clk);
    if (!hold) tx_start = 1'b0;
  endtask

  // Starting at the falling edge after edge N, check all 40 line samples,
  // then the DONE cycle after edge N+40. inject_at >= 0 re-requests 0xFF
  // mid-frame for three clocks.
  task automatic check_frame(input logic [9:0] line, input int inject_at);
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 4; j++) begin
        if (inject_at >= 0 && (k * 4 + j) == inject_at) begin
          tx_data  = 8'hFF;
          tx_start = 1'b1;
        end
        if (inject_at >= 0 && (k * 4 + j) == inject_at + 3) tx_start = 1'b0;
        chk($sformatf("tx_slot%0d_%0d", k, j), tx_o, line[k]);
        chk("busy_in_frame", busy_o, 1'b1);
        @(negedge clk);
      end
    end
    chk("done_pulse", done_o, 1'b1);
    chk("done_busy", busy_o, 1'b1);
    chk("done_line", tx_o, 1'b1);
  endtask

  task automatic check_idle_after;
    @(negedge clk);
    chk("done_cleared", done_o, 1'b0);
    chk("busy_cleared", busy_o, 1'b0);
    chk("idle_line", tx_o, 1'b1);
    chk("idle_state", fsm_state, 3'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    logic [9:0] line;      // slot k of the line at bit k
    int         inject_at; // -1: no mid-frame request
  } vec_t;

  vec_t vec[6];

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    vec[0] = '{8'hA5, 10'b1101001010, -1};
    vec[1] = '{8'h00, 10'b1000000000, -1};
    vec[2] = '{8'hFF, 10'b1111111110, -1};
    vec[3] = '{8'h3C, 10'b1001111000, 12};
    vec[4] = '{8'h01, 10'b1000000010, -1};
    vec[5] = '{8'h80, 10'b1100000000, -1};

    rst = 1'b0; tx_start = 1'b0; tx_data = 8'h00;
    big_start = 1'b0; big_data = 8'h00;

    // Asynchronous reset before any clock edge.
    #3 rst = 1'b1;
    #1;
    chk("reset_tx", tx_o, 1'b1);
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_done", done_o, 1'b0);
    chk("reset_state", fsm_state, 3'd0);
    chk("reset_big_tx", big_tx, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Table-driven single frames.
    for (int v = 0; v < 6; v++) begin
      d0 = done_seen;
      issue(vec[v].data, 1'b1, 1'b0);
      check_frame(vec[v].line, vec[v].inject_at);
      check_idle_after();
      repeat (3) @(negedge clk);
      chk($sformatf("done_count_v%0d", v), done_seen - d0, 1);
    end

    // Back-to-back with the request held: 0x00 then 0xFF.
    d0 = done_seen;
    issue(8'h00, 1'b1, 1'b1);
    tx_data = 8'hFF;
    exp_q.push_back(8'hFF);
    check_frame(10'b1000000000, -1);
    @(negedge clk);
    chk("b2b_second_start", tx_o, 1'b0);
    chk("b2b_busy", busy_o, 1'b1);
    chk("b2b_done_low", done_o, 1'b0);
    tx_start = 1'b0;
    check_frame(10'b1111111110, -1);
    check_idle_after();
    repeat (3) @(negedge clk);
    chk("b2b_done_count", done_seen - d0, 2);

    // Reset during bit 3 of 0x55, then a fresh 0x55.
    d0 = done_seen;
    issue(8'h55, 1'b0, 1'b0);
    repeat (17) @(negedge clk);
    chk("abort_bit3", tx_o, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("abort_tx", tx_o, 1'b1);
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_done", done_o, 1'b0);
    chk("abort_state", fsm_state, 3'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("abort_no_done", done_seen - d0, 0);
    d0 = done_seen;
    issue(8'h55, 1'b1, 1'b0);
    check_frame(10'b1010101010, -1);
    check_idle_after();
    repeat (3) @(negedge clk);
    chk("after_abort_done_count", done_seen - d0, 1);

    // BAUD_DIV=434: send 0x41.
    @(negedge clk);
    big_data  = 8'h41;
    big_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    big_start = 1'b0;
    big_data  = 8'h00;
    for (int idx = 0; idx <= 4341; idx++) begin
      logic [9:0] big_line;
      big_line = 10'b1010000010;
      if (idx < 4340 && (idx % 434) == 217)
        chk($sformatf("big_slot%0d", idx / 434), big_tx, big_line[idx / 434]);
      if (idx == 433)  chk("big_start_end", big_tx, 1'b0);
      if (idx == 434)  chk("big_bit0_begin", big_tx, 1'b1);
      if (idx == 4339) chk("big_done_early", big_done, 1'b0);
      if (idx == 4340) begin
        chk("big_done", big_done, 1'b1);
        chk("big_done_busy", big_busy, 1'b1);
      end
      if (idx == 4341) begin
        chk("big_done_clear", big_done, 1'b0);
        chk("big_busy_clear", big_busy, 1'b0);
        chk("big_idle_line", big_tx, 1'b1);
      end
      if (idx < 4341) @(negedge clk);
    end

    // Every expected byte must have been decoded.
    repeat (10) @(negedge clk);
    chk("sb_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
